pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//   Parametrised pipeline register chain for inter-stage buses (PC+4, ALU result, control).
//   DEPTH cascaded stages of WIDTH bits, each with a valid bit.
//   Adds stall (hold), flush (bubble insert), occupancy count and upstream ready.
//   Sits between any two pipeline stages; DEPTH=1 replaces the single-register stage latches.
// PARAMETERS
//   WIDTH      32  data bits per stage
//   DEPTH      1   number of cascaded stages, legal range 1..8
//   RESET_VAL  0   value loaded into every stage data register on reset and on flush
// PORTS
//   clk        in   1              pipeline clock; all state updates on the FALLING edge
//   reset      in   1              synchronous, active-low; sampled on the falling clk edge
//   in_valid   in   1              upstream presents a valid word
//   in_data    in   WIDTH          upstream word
//   in_ready   out  1              chain accepts in_data at the next falling edge
//   stall      in   1              hold request from hazard unit
//   flush      in   1              squash every stage
//   out_valid  out  1              valid bit of stage DEPTH-1
//   out_data   out  WIDTH          data of stage DEPTH-1
//   occupancy  out  $clog2(DEPTH+1) number of valid stages
// BEHAVIOUR
//   - State: data[k], valid[k] for k=0..DEPTH-1. Stage 0 is nearest the input.
//   - Priority at each falling edge: reset==0 > flush > stall > normal shift.
//   - reset==0: all valid[k]=0, data[k]=RESET_VAL. So out_valid=0, out_data=RESET_VAL,
//     occupancy=0 and in_ready=1 from the edge after reset is sampled. Overrides flush/stall.
//     Reset mid-stream discards all contents.
//   - flush=1: all valid[k]=0, data[k]=RESET_VAL. in_data is discarded even if in_valid=1.
//     Flush wins over a simultaneous stall.
//   - normal (stall=0): data[0]<=in_data, valid[0]<=in_valid, data[k]<=data[k-1],
//     valid[k]<=valid[k-1]. The out-stage word is consumed. Latency is exactly DEPTH
//     falling edges from acceptance to out_valid.
//   - in_data with in_valid=0 still shifts into the data regs; only the valid bit marks bubbles.
//   - stall=1 (macro off): every stage holds data and valid. in_ready=0, and upstream
//     must hold its word.
//   - in_ready = !stall (macro off). in_ready is combinational from stall and registered state.
//   - occupancy = popcount(valid), combinational from registers. Max is DEPTH, min is 0,
//     and it never wraps.
//   - out_data and out_valid come straight from stage DEPTH-1 registers. No comb path from inputs.
// CONFIGURATION
//   PIPE_BUBBLE_COLLAPSE_EN (defined) changes stall=1 behaviour:
//     - stage DEPTH-1 holds.
//     - free[DEPTH-1] = !valid[DEPTH-1].
//     - for k<DEPTH-1: mv[k] = valid[k] & free[k+1]; free[k] = !valid[k] | mv[k].
//     - stage k+1 loads stage k when mv[k]. A stage vacated and not refilled clears its valid.
//     - stage 0 loads in_data/in_valid when free[0].
//     - in_ready = !stall | free[0].
//     - bubbles are squeezed out while the output is frozen.
//   Macro undefined: all stages freeze on stall and in_ready = !stall. No collapse logic is built.
// TESTING (WIDTH=32, DEPTH=3 unless noted)
//   1. reset=0 for 2 edges with in_valid=1 -> out_valid=0, out_data=0, occupancy=0.
//      After release, in_ready=1.
//   2. Push 0x10,0x14,0x18 on 3 consecutive edges, stall=0 -> out_data=0x10 with out_valid=1
//      on edge 3, 0x14 on edge 4, 0x18 on edge 5. occupancy peaks at 3.
//   3. Chain full (0x10,0x14,0x18), stall=1 for 4 edges -> outputs stay at 0x10, in_ready=0,
//      occupancy=3. After release, the sequence resumes unchanged.
//   4. Chain full, flush=1 together with stall=1 -> next edge: occupancy=0, out_valid=0,
//      out_data=RESET_VAL. A concurrently offered in_data=0xAA never appears.
//   5. Collapse build: stage pattern valid={1,0,1} (0x20 out, 0x24 in stage 0), stall=1,
//      in_valid=1 with 0x28 -> edge 1: stages={0x20,0x24,0x28}, occupancy=3, in_ready=0 next.
//      Non-collapse build: no change, in_ready=0.
//   6. DEPTH=1, WIDTH=8 -> 0x5A appears one edge after acceptance.
//      reset=0 mid-stall clears out_valid on that edge.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Bus bundle for pipe_stage_chain: upstream word/handshake, stall/flush controls,
// and the downstream word with occupancy.
interface pipe_stage_chain_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  // master drives the chain, slave is the chain itself
  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/data register chain updating on the falling clock edge, with
// stall, flush and occupancy. Optional PIPE_BUBBLE_COLLAPSE_EN squeezes bubbles on stall.
module pipe_stage_chain #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic               clk,
  input logic               reset,
  pipe_stage_chain_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  logic [DEPTH-1:0] free_c;
  logic [DEPTH-1:0] mv_c;

  // Free/move chain resolved from the frozen output stage back towards the input
  always_comb begin
    free_c = '0;
    mv_c   = '0;
    free_c[DEPTH-1] = !valid_q[DEPTH-1];
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      mv_c[k]   = valid_q[k] & free_c[k+1];
      free_c[k] = !valid_q[k] | mv_c[k];
    end
  end
`endif

  always_ff @(negedge clk) begin
    if (!reset || bus.flush) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= RESET_VAL;
    end else if (!bus.stall) begin
      data_q[0]  <= bus.in_data;
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < int'(DEPTH); k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
`ifdef PIPE_BUBBLE_COLLAPSE_EN
    else begin
      if (free_c[0]) begin
        data_q[0]  <= bus.in_data;
        valid_q[0] <= bus.in_valid;
      end
      // A stage that hands its word on and receives nothing becomes a bubble
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (mv_c[k-1]) begin
          data_q[k]  <= data_q[k-1];
          valid_q[k] <= 1'b1;
        end else if (mv_c[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
`endif
  end

  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = OCC_W'($countones(valid_q));
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  assign bus.in_ready  = !bus.stall | free_c[0];
`else
  assign bus.in_ready  = !bus.stall;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a DEPTH=3/WIDTH=32 chain driven from a vector
// table plus short sequences, and a DEPTH=1/WIDTH=8 chain for the single-stage case.
module tb_pipe_stage_chain;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  logic clk;
  logic rst3;
  logic rst1;
  int   vectors;
  int   miscompares;

  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(3)) b3 ();
  pipe_stage_chain_if #(.WIDTH(8),  .DEPTH(1)) b1 ();

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u3 (
    .clk(clk), .reset(rst3), .bus(b3.slave)
  );
  pipe_stage_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] d;
    logic        st;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic iv, input logic [31:0] d,
                     input logic st, input logic fl, input logic ev,
                     input logic [31:0] ed, input logic [1:0] eo, input logic er);
    vec_t v;
    v.rst = rst; v.iv = iv; v.d = d; v.st = st; v.fl = fl;
    v.ev = ev; v.ed = ed; v.eo = eo; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive3(input logic r, input logic iv, input logic [31:0] d,
                        input logic st, input logic fl);
    rst3 = r; b3.in_valid = iv; b3.in_data = d; b3.stall = st; b3.flush = fl;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check3(input string tag, input logic ev, input logic [31:0] ed,
                        input logic [1:0] eo, input logic er);
    chk({tag, ".out_valid"}, 32'(b3.out_valid), 32'(ev));
    chk({tag, ".out_data"},  b3.out_data,       ed);
    chk({tag, ".occupancy"}, 32'(b3.occupancy), 32'(eo));
    chk({tag, ".in_ready"},  32'(b3.in_ready),  32'(er));
  endtask

  task automatic check1(input string tag, input logic ev, input logic [7:0] ed,
                        input logic eo, input logic er);
    chk({tag, ".out_valid"}, 32'(b1.out_valid), 32'(ev));
    chk({tag, ".out_data"},  32'(b1.out_data),  32'(ed));
    chk({tag, ".occupancy"}, 32'(b1.occupancy), 32'(eo));
    chk({tag, ".in_ready"},  32'(b1.in_ready),  32'(er));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    drive3(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst1 = 1'b0; b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.stall = 1'b0; b1.flush = 1'b0;

    // rst iv data stall flush | out_valid out_data occ in_ready
    add(0, 1, 32'h99, 0, 0,  0, 32'h00, 0, 1);
    add(0, 1, 32'h99, 0, 0,  0, 32'h00, 0, 1);
    add(1, 1, 32'h10, 0, 0,  0, 32'h00, 1, 1);
    add(1, 1, 32'h14, 0, 0,  0, 32'h00, 2, 1);
    add(1, 1, 32'h18, 0, 0,  1, 32'h10, 3, 1);
    for (int i = 0; i < 4; i++) add(1, 1, 32'h1C, 1, 0,  1, 32'h10, 3, 0);
    add(1, 1, 32'h1C, 0, 0,  1, 32'h14, 3, 1);
    add(1, 1, 32'h20, 0, 0,  1, 32'h18, 3, 1);
    add(1, 1, 32'hAA, 1, 1,  0, 32'h00, 0, COLLAPSE);
    add(1, 0, 32'h00, 0, 0,  0, 32'h00, 0, 1);
    add(1, 0, 32'h00, 0, 0,  0, 32'h00, 0, 1);
    add(1, 0, 32'h55, 0, 0,  0, 32'h00, 0, 1);
    add(1, 0, 32'h00, 0, 0,  0, 32'h00, 0, 1);
    add(1, 0, 32'h00, 0, 0,  0, 32'h55, 0, 1);
    add(1, 1, 32'h30, 0, 0,  0, 32'h00, 1, 1);
    add(0, 1, 32'h31, 0, 0,  0, 32'h00, 0, 1);
    add(1, 0, 32'h00, 0, 0,  0, 32'h00, 0, 1);

    foreach (tbl[i]) begin
      drive3(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].st, tbl[i].fl);
      tick();
      check3($sformatf("row%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].er);
    end

    // Hole in the middle of the chain: stages {0x20, bubble, 0x24}, then stall
    drive3(1, 1, 32'h20, 0, 0); tick();
    drive3(1, 0, 32'h99, 0, 0); tick();
    drive3(1, 1, 32'h24, 0, 0); tick();
    check3("hole.fill", 1, 32'h20, 2, 1);
    drive3(1, 1, 32'h28, 1, 0); tick();
    check3("hole.stall", 1, 32'h20, COLLAPSE ? 2'd3 : 2'd2, 0);
    drive3(1, 0, 32'h00, 0, 0); tick();
    if (COLLAPSE) check3("hole.rel1", 1, 32'h24, 2, 1);
    else          check3("hole.rel1", 0, 32'h99, 1, 1);
    tick();
    if (COLLAPSE) check3("hole.rel2", 1, 32'h28, 1, 1);
    else          check3("hole.rel2", 1, 32'h24, 1, 1);

    // Single-stage chain
    tick();
    check1("d1.reset", 0, 8'h00, 0, 1);
    rst1 = 1'b1; b1.in_valid = 1'b1; b1.in_data = 8'h5A; tick();
    check1("d1.push", 1, 8'h5A, 1, 1);
    b1.stall = 1'b1; b1.in_data = 8'h66; tick();
    check1("d1.stall", 1, 8'h5A, 1, 0);
    rst1 = 1'b0; tick();
    check1("d1.rst_stall", 0, 8'h00, 0, COLLAPSE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
